// File: rtl/nco_pkg.sv
// nco_pkg: shared constants for the multi-channel NCO.
//   CH_W            width of channel tags and write addresses
//   WR_FREQ/OFF/ACC register-write select codes (code 3 is ignored)
//   latency()       slot-to-output latency for a given sin/cos latency
package nco_pkg;

    localparam int CH_W = 4;

    localparam logic [1:0] WR_FREQ = 2'd0;
    localparam logic [1:0] WR_OFF  = 2'd1;
    localparam logic [1:0] WR_ACC  = 2'd2;

    // One cycle for the phase register, scLat for sin/cos, one for the output register.
    function automatic int latency(input int scLat);
        return scLat + 2;
    endfunction

endpackage

// File: rtl/nco_sincos.sv
// nco_sincos: pipelined sin/cos generator.
//   ipClk    clock
//   ipPhase  phase, full circle = 2^LUT_PHASE_W
//   opSin    round(A*sin), A = 2^(OUT_W-1)-1, two's complement
//   opCos    round(A*cos)
// Latency is exactly SC_LAT cycles (SC_LAT >= 3). There is no reset; the
// parent tracks validity. Both outputs share one quarter-wave ROM: the
// cosine path looks up sin(phase + 90 deg). The ROM holds 2^10+2 coarse
// points carrying extra fraction bits, and the remaining low phase bits
// linearly interpolate between neighbours, which keeps the error well
// under one output LSB. LUT_PHASE_W must be at least 13.
module nco_sincos #(
    parameter int LUT_PHASE_W = 21,
    parameter int OUT_W       = 19,
    parameter int SC_LAT      = 3
) (
    input  logic                           ipClk,
    input  logic        [LUT_PHASE_W-1:0]  ipPhase,
    output logic signed [OUT_W-1:0]        opSin,
    output logic signed [OUT_W-1:0]        opCos
);

    localparam int  QW     = LUT_PHASE_W - 2;   // bits inside one quadrant
    localparam int  ROM_AW = 10;
    localparam int  FW     = QW - ROM_AW;       // interpolation fraction bits
    localparam int  ROM_N  = (1 << ROM_AW) + 2; // +1 for the 90 deg point, +1 so idx+1 never overruns
    localparam int  GUARD  = 4;                 // extra fraction bits held in the ROM
    localparam int  RW     = OUT_W + GUARD;
    localparam int  SW     = RW + FW + 3;
    localparam real AMP    = real'((2 ** (OUT_W - 1)) - 1) * real'(2 ** GUARD);
    localparam logic signed [SW-1:0] RND = SW'(1) << (FW + GUARD - 1);

    function automatic logic [RW-1:0] romEntry(input int i);
        real ang;
        ang = 1.5707963267948966 * real'(i) / real'(1 << ROM_AW);
        return RW'($rtoi(AMP * $sin(ang) + 0.5));
    endfunction

    logic [RW-1:0] rom [ROM_N];
    for (genvar i = 0; i < ROM_N; i++) begin : gRom
        localparam logic [RW-1:0] V = romEntry(i);
        assign rom[i] = V;
    end

    logic signed [OUT_W-1:0] pathOut [2];

    // Path 0 = sine, path 1 = cosine.
    for (genvar k = 0; k < 2; k++) begin : gPath
        localparam logic [LUT_PHASE_W-1:0] PH_OFF = (k == 0) ? '0 : (LUT_PHASE_W'(1) << QW);

        logic [LUT_PHASE_W-1:0]  ph;
        logic [QW:0]             r, x;
        logic [ROM_AW:0]         idxA;
        logic [FW-1:0]           fracA, fracB;
        logic                    negA, negB;
        logic [RW-1:0]           s0B, s1B;
        logic signed [RW+1:0]    diff;
        logic signed [SW-1:0]    sum, shifted;
        logic signed [OUT_W-1:0] mag;
        logic signed [OUT_W-1:0] dly [SC_LAT-2];

        // Fold onto the first quadrant: odd quadrants mirror the index,
        // the upper half-circle negates the result.
        always_comb begin
            ph = ipPhase + PH_OFF;
            r  = {1'b0, ph[QW-1:0]};
            x  = ph[QW] ? (((QW + 1)'(1) << QW) - r) : r;
        end

        always_comb begin
            diff    = $signed({2'b0, s1B}) - $signed({2'b0, s0B});
            sum     = $signed({3'b0, s0B, {FW{1'b0}}})
                    + SW'(diff) * SW'($signed({1'b0, fracB})) + RND;
            shifted = sum >>> (FW + GUARD);
            mag     = OUT_W'(shifted);
        end

        always_ff @(posedge ipClk) begin
            idxA  <= x[QW:FW];
            fracA <= x[FW-1:0];
            negA  <= ph[LUT_PHASE_W-1];
            s0B   <= rom[idxA];
            s1B   <= rom[idxA + (ROM_AW + 1)'(1)];
            fracB <= fracA;
            negB  <= negA;
            dly[0] <= negB ? -mag : mag;
            for (int j = 1; j <= SC_LAT - 3; j++) dly[j] <= dly[j-1];
        end

        assign pathOut[k] = dly[SC_LAT-3];
    end

    assign opSin = pathOut[0];
    assign opCos = pathOut[1];

endmodule

// File: rtl/nco_multi.sv
// nco_multi: time-multiplexed NCO, CHANNELS channels through one phase
// pipeline and one sin/cos generator, one round-robin sample per clock.
//   ipClk, Reset         clock, synchronous active-high reset
//   ipWrEn/ipWrAddr/     single-cycle register write: sel 0 freq step,
//   ipWrSel/ipWrData     1 phase offset, 2 accumulator load, 3 ignored
//   ipSync               zero all accumulators and restart at channel 0
//   opValid/opChannel    sample valid and its channel tag
//   opSin/opCos          sample values, two's complement
// A slot at cycle t appears on the outputs LATENCY = SC_LAT+2 cycles later.
module nco_multi
    import nco_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int PHASE_W     = 32,
    parameter int LUT_PHASE_W = 21,
    parameter int OUT_W       = 19,
    parameter int SC_LAT      = 3
) (
    input  logic                      ipClk,
    input  logic                      Reset,
    input  logic                      ipWrEn,
    input  logic [CH_W-1:0]           ipWrAddr,
    input  logic [1:0]                ipWrSel,
    input  logic [PHASE_W-1:0]        ipWrData,
    input  logic                      ipSync,
    output logic                      opValid,
    output logic [CH_W-1:0]           opChannel,
    output logic signed [OUT_W-1:0]   opSin,
    output logic signed [OUT_W-1:0]   opCos
);

    localparam int LAT   = latency(SC_LAT);
    localparam int SHIFT = PHASE_W - LUT_PHASE_W;

    logic [PHASE_W-1:0]     acc  [CHANNELS];
    logic [PHASE_W-1:0]     freq [CHANNELS];
    logic [PHASE_W-1:0]     off  [CHANNELS];
    logic [CH_W-1:0]        ch;
    logic [PHASE_W-1:0]     accCur, offCur, phase;
    logic [CHANNELS-1:0]    wrHit;
    logic [LUT_PHASE_W-1:0] phQ;
    logic [LAT:1]           vldPipe;
    logic [LAT:1][CH_W-1:0] tagPipe;
    logic signed [OUT_W-1:0] scSin, scCos;

    // Addresses >= CHANNELS match no channel and so are dropped.
    always_comb begin
        wrHit  = '0;
        accCur = '0;
        offCur = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wrHit[c] = ipWrEn && (ipWrAddr == CH_W'(c));
            if (ch == CH_W'(c)) begin
                accCur = acc[c];
                offCur = off[c];
            end
        end
        phase = accCur + offCur;
    end

    always_ff @(posedge ipClk) begin
        if (Reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                acc[c]  <= '0;
                freq[c] <= '0;
                off[c]  <= '0;
            end
            ch      <= '0;
            phQ     <= '0;
            vldPipe <= '0;
            tagPipe <= '0;
            opSin   <= '0;
            opCos   <= '0;
        end else begin
            // Priority on acc: sync, then load, then the slot's own increment.
            for (int c = 0; c < CHANNELS; c++) begin
                if (wrHit[c] && ipWrSel == WR_FREQ) freq[c] <= ipWrData;
                if (wrHit[c] && ipWrSel == WR_OFF)  off[c]  <= ipWrData;
                if (ipSync)                                acc[c] <= '0;
                else if (wrHit[c] && ipWrSel == WR_ACC)    acc[c] <= ipWrData;
                else if (ch == CH_W'(c))                   acc[c] <= acc[c] + freq[c];
            end
            ch      <= (ipSync || ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;
            phQ     <= LUT_PHASE_W'(phase >> SHIFT);
            vldPipe <= {vldPipe[LAT-1:1], 1'b1};
            tagPipe <= {tagPipe[LAT-1:1], ch};
            opSin   <= scSin;
            opCos   <= scCos;
        end
    end

    nco_sincos #(
        .LUT_PHASE_W (LUT_PHASE_W),
        .OUT_W       (OUT_W),
        .SC_LAT      (SC_LAT)
    ) uSinCos (
        .ipClk   (ipClk),
        .ipPhase (phQ),
        .opSin   (scSin),
        .opCos   (scCos)
    );

    assign opValid   = vldPipe[LAT];
    assign opChannel = tagPipe[LAT];

endmodule

// File: tb/tb_nco_multi.sv
module tb_nco_multi;
    import nco_pkg::*;

    localparam int LAT = latency(3);
    localparam int A   = 262143;
    localparam int NA  = -262143;
    localparam int S22 = 100318;  // A*sin(22.5 deg)
    localparam int C22 = 242189;  // A*cos(22.5 deg)
    localparam int S45 = 185363;  // A*sin(45 deg)

    logic               ipClk = 1'b0;
    logic               Reset = 1'b1;
    logic               ipWrEn = 1'b0;
    logic [3:0]         ipWrAddr = '0;
    logic [1:0]         ipWrSel = '0;
    logic [31:0]        ipWrData = '0;
    logic               ipSync = 1'b0;
    logic               opValid;
    logic [3:0]         opChannel;
    logic signed [18:0] opSin, opCos;

    nco_multi #(.CHANNELS(4), .PHASE_W(32), .LUT_PHASE_W(21), .OUT_W(19), .SC_LAT(3)) dut (
        .ipClk(ipClk), .Reset(Reset), .ipWrEn(ipWrEn), .ipWrAddr(ipWrAddr),
        .ipWrSel(ipWrSel), .ipWrData(ipWrData), .ipSync(ipSync),
        .opValid(opValid), .opChannel(opChannel), .opSin(opSin), .opCos(opCos)
    );

    always #5 ipClk = ~ipClk;

    int nChecks = 0;
    int nPass   = 0;
    int eSin [64], eCos [64], eTol [64];

    task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
        nChecks++;
        if ((obs - exp) <= tol && (exp - obs) <= tol) nPass++;
        else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    endtask

    task automatic tick();
        @(posedge ipClk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [3:0] addr, input logic [31:0] data);
        ipWrEn = 1'b1; ipWrSel = sel; ipWrAddr = addr; ipWrData = data;
        tick();
        ipWrEn = 1'b0;
    endtask

    task automatic syncNow();
        ipSync = 1'b1;
        tick();
        ipSync = 1'b0;
    endtask

    task automatic setAll(input int n);
        for (int k = 0; k < n; k++) begin
            eSin[k] = 0; eCos[k] = A; eTol[k] = 0;
        end
    endtask

    task automatic setExp(input int k, input int s, input int c, input int tol);
        eSin[k] = s; eCos[k] = c; eTol[k] = tol;
    endtask

    // Called right after syncNow: slot k is the k-th cycle after the sync.
    // Optional write at iteration wrJ and sync at syncJ (0 = none); the
    // stimulus of iteration j lands in slot j-1.
    task automatic runSlots(input string tag, input int n, input int wrJ, input logic [1:0] sel,
                            input logic [3:0] addr, input logic [31:0] data, input int syncJ);
        for (int j = 1; j < n + LAT; j++) begin
            ipWrEn = (j == wrJ); ipWrSel = sel; ipWrAddr = addr; ipWrData = data;
            ipSync = (j == syncJ);
            tick();
            ipWrEn = 1'b0; ipSync = 1'b0;
            if (j >= LAT) begin
                int k;
                int ec;
                k  = j - LAT;
                ec = (syncJ > 0 && k >= syncJ) ? (k - syncJ) % 4 : k % 4;
                check($sformatf("%s.vld%0d", tag, k), int'(opValid), 1);
                check($sformatf("%s.ch%0d", tag, k), int'(opChannel), ec);
                check($sformatf("%s.sin%0d", tag, k), int'(opSin), eSin[k], eTol[k]);
                check($sformatf("%s.cos%0d", tag, k), int'(opCos), eCos[k], eTol[k]);
            end
        end
    endtask

    task automatic resetSeq(input string tag);
        Reset = 1'b1;
        tick();
        check({tag, ".vld"}, int'(opValid), 0);
        check({tag, ".ch"}, int'(opChannel), 0);
        check({tag, ".sin"}, int'(opSin), 0);
        check({tag, ".cos"}, int'(opCos), 0);
        Reset = 1'b0;
        for (int j = 1; j < LAT + 8; j++) begin
            tick();
            if (j < LAT) check($sformatf("%s.idle%0d", tag, j), int'(opValid), 0);
            else begin
                check($sformatf("%s.vld%0d", tag, j), int'(opValid), 1);
                check($sformatf("%s.ch%0d", tag, j), int'(opChannel), (j - LAT) % 4);
                check($sformatf("%s.sin%0d", tag, j), int'(opSin), 0);
                check($sformatf("%s.cos%0d", tag, j), int'(opCos), A);
            end
        end
    endtask

    initial begin
        resetSeq("rst");

        // Channel 1 at a quarter turn per slot.
        wr(WR_FREQ, 4'd1, 32'h4000_0000);
        syncNow();
        setAll(16);
        setExp(5, A, 0, 0); setExp(9, 0, NA, 0); setExp(13, NA, 0, 0);
        runSlots("quad", 16, 0, WR_FREQ, 4'd0, 32'h0, 0);

        // Offset write during channel 2's own slot (slot 2).
        wr(WR_FREQ, 4'd1, 32'h0);
        syncNow();
        setAll(12);
        setExp(6, A, 0, 0); setExp(10, A, 0, 0);
        runSlots("off", 12, 3, WR_OFF, 4'd2, 32'h4000_0000, 0);

        // Sync at slot 9 together with a losing accumulator load to channel 3.
        wr(WR_FREQ, 4'd0, 32'h1000_0000);
        wr(WR_FREQ, 4'd3, 32'h4000_0000);
        syncNow();
        setAll(20);
        setExp(2, A, 0, 0);  setExp(6, A, 0, 0);  setExp(12, A, 0, 0); setExp(16, A, 0, 0);
        setExp(4, S22, C22, 1);  setExp(8, S45, S45, 1);
        setExp(14, S22, C22, 1); setExp(18, S45, S45, 1);
        setExp(7, A, 0, 0);  setExp(17, A, 0, 0);
        runSlots("sync", 20, 10, WR_ACC, 4'd3, 32'h8000_0000, 10);

        // Accumulator wrap at 2^32 with a small step.
        wr(WR_FREQ, 4'd0, 32'd2);
        wr(WR_FREQ, 4'd3, 32'h0);
        syncNow();
        setAll(13);
        setExp(2, A, 0, 0); setExp(6, A, 0, 0); setExp(10, A, 0, 0);
        setExp(4, 0, A, 1); setExp(8, 0, A, 1); setExp(12, 0, A, 1);
        runSlots("wrap", 13, 2, WR_ACC, 4'd0, 32'hFFFF_FFFF, 0);

        // Wrap with a visible step: 270 deg -> 0 -> 90 deg.
        wr(WR_FREQ, 4'd0, 32'h4000_0000);
        syncNow();
        setAll(13);
        setExp(2, A, 0, 0); setExp(6, A, 0, 0); setExp(10, A, 0, 0);
        setExp(4, NA, 0, 0); setExp(12, A, 0, 0);
        runSlots("wrap2", 13, 2, WR_ACC, 4'd0, 32'hC000_0000, 0);

        // Out-of-range address and select 3 must change nothing.
        wr(WR_FREQ, 4'd0, 32'h0);
        wr(WR_FREQ, 4'd5, 32'h4000_0000);
        wr(2'd3, 4'd2, 32'h0);
        syncNow();
        setAll(8);
        setExp(2, A, 0, 0); setExp(6, A, 0, 0);
        runSlots("ign", 8, 0, WR_FREQ, 4'd0, 32'h0, 0);

        resetSeq("mid");

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/nco_multi.md
# nco_multi

Time-multiplexed, parametrised numerically controlled oscillator that serves CHANNELS independent channels from one phase pipeline and one sin/cos generator. Each channel has its own frequency step, phase offset and phase accumulator, all loaded over a single-cycle register-write port. Outputs form a channel-tagged sample stream, one sample per clock, round-robin. The block sits between the control register bank and the mixers/up-converters in the DSP chain.

## Interface
- CHANNELS, 4: number of channels, 1..16
- PHASE_W, 32: accumulator, frequency and offset width
- LUT_PHASE_W, 21: phase bits presented to the sin/cos generator, at most PHASE_W
- OUT_W, 19: signed sin/cos output width
- SC_LAT, 3: fixed latency of the sin/cos sub-module, in cycles
- ipClk  in  1  clock
- Reset  in  1  synchronous, active-high reset, sampled on ipClk
- ipWrEn  in  1  register write strobe, single cycle
- ipWrAddr  in  4  target channel
- ipWrSel  in  2  0 = frequency step, 1 = phase offset, 2 = accumulator load, 3 = ignored
- ipWrData  in  PHASE_W  write value
- ipSync  in  1  clears all accumulators and restarts the slot sequence
- opValid  out  1  sample valid
- opChannel  out  4  channel of the current sample
- opSin  out  OUT_W  sine, two's complement
- opCos  out  OUT_W  cosine, two's complement

## Operation
- Slot counter ch: increments each cycle and wraps CHANNELS-1 -> 0. Each cycle is the slot of channel ch.
- Slot of channel c:
  - Emitted phase p = acc[c] + off[c], mod 2^PHASE_W, using the pre-increment value.
  - Then acc[c] <= acc[c] + freq[c], mod 2^PHASE_W, wrapping silently.
  - The top LUT_PHASE_W bits of p are passed on truncated, with no rounding and no dither.
- Output frequency of channel c: freq[c] * f_clk / (CHANNELS * 2^PHASE_W).
- Amplitude: full scale A = 2^(OUT_W-1)-1. opSin = round(A*sin(2π p/2^PHASE_W)), opCos likewise, with ±1 LSB tolerance.
- Writes:
  - A write updates the register at the end of its cycle.
  - A slot in the same cycle as a write to its own channel uses the old value.
  - An ipWrAddr value >= CHANNELS is ignored, as is ipWrSel = 3.
- Accumulator load (sel 2) to the channel in its own slot: the load wins and the increment is discarded.
- ipSync in a cycle has these effects:
  - Every acc <= 0. This overrides increments and loads in the same cycle.
  - ch <= 0.
  - freq and off are kept. A freq or off write in the same cycle still takes effect.
  - Samples already in the pipeline still emerge unchanged.
- Reset behaviour:
  - acc, freq, off, ch, the pipeline valid bits, opValid, opChannel, opSin and opCos are all cleared to 0.
  - Reset mid-operation drops all in-flight samples. The first valid sample after reset appears LATENCY cycles after the first cycle with Reset low.

## Timing
- LATENCY = SC_LAT + 2. Slot cycle t leads to opValid/opChannel/opSin/opCos registered at t+LATENCY.
- Pipeline stages:
  - Stage 1 registers the truncated phase and channel tag.
  - The sin/cos sub-module takes SC_LAT cycles.
  - The output register takes 1 cycle.
- Once the pipeline fills, opValid stays continuously high with no gaps. opChannel runs 0,1,…,CHANNELS-1,0,…
- A write at cycle w to channel c first affects the first slot of c at a cycle > w.
- ipSync at cycle s: the channel-0 slot at s+1 emits phase off[0], visible at s+1+LATENCY.
- CHANNELS = 1 degenerates to a single continuous NCO updating every cycle.

## Structure
- Shared package nco_pkg holds:
  - the write-select constants WR_FREQ = 0, WR_OFF = 1, WR_ACC = 2
  - the LATENCY function of SC_LAT
  - the channel-tag width constant (4)
- Register arrays acc/freq/off are flat arrays indexed by channel, implemented as distributed RAM or flops.
- One sub-module, nco_sincos: phase in (LUT_PHASE_W), sin/cos out (OUT_W), fixed SC_LAT pipeline, quarter-wave ROM with symmetry folding. There is no reset inside it; validity is tracked by the parent.

## Test plan
- Reset, then freq = off = 0 on all channels -> after LATENCY cycles opValid = 1 continuously, opChannel cycles 0..3, opSin = 0, opCos = 262143.
- CHANNELS = 4, freq[1] = 0x4000_0000 -> channel-1 samples cycle (sin, cos) = (0, 262143), (262143, 0), (0, -262143), (-262143, 0), repeating; other channels are unchanged.
- off[2] = 0x4000_0000 written with freq[2] = 0 -> channel-2 samples become sin = 262143, cos = 0 from its next slot; a write in the same cycle as the channel-2 slot shows the old value for that slot.
- freq[0] = 0x1000_0000 running, ipSync pulsed, with an acc load to channel 3 in the same cycle -> the next channel-0 sample has phase 0, channel 3 accumulates from 0, and in-flight samples are unaltered.
- Accumulator wrap: acc[0] loaded with 0xFFFF_FFFF and freq[0] = 2 -> the following channel-0 phase is 0x0000_0001, with no glitch.
- Reset asserted mid-stream for 1 cycle -> opValid drops the next cycle, all outputs are 0, and the stream restarts at channel 0 LATENCY cycles later.
